onehot_index_encoder: RTL and testbench

//  Inverse of the one-hot select mux path: converts a one-hot select vector back to its binary key.
//  Two-stage registered pipeline with valid/ready handshake on both sides.

---
 rtl/onehot_index_encoder.sv | 118 +++++++++++
 tb/tb_onehot_index_encoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_index_encoder.sv
// One-hot to binary key encoder: two-stage valid/ready pipeline with malformed-vector flags.
// Optional saturating malformed-output counter enabled by ONEHOT_INDEX_ERRCNT_EN.
module onehot_index_encoder #(
    parameter int NR_KEY    = 4,
    parameter int KEY_WIDTH = $clog2(NR_KEY),
    parameter int DEF_INDEX = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NR_KEY-1:0]    in_onehot,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [KEY_WIDTH-1:0] out_index,
    output logic                 out_err,
    output logic                 out_multi,
    output logic [15:0]          err_cnt
);

    if (NR_KEY < 2 || NR_KEY > 2**KEY_WIDTH) begin : g_bad_key
        $error("onehot_index_encoder: need 2 <= NR_KEY <= 2**KEY_WIDTH");
    end
    if (DEF_INDEX < 0 || DEF_INDEX >= NR_KEY) begin : g_bad_def
        $error("onehot_index_encoder: DEF_INDEX out of range");
    end

    logic                 a_valid;
    logic [NR_KEY-1:0]    a_vec;
    logic                 a_zero;
    logic                 a_multi;
    logic                 b_valid;
    logic [KEY_WIDTH-1:0] b_index;
    logic                 b_err;
    logic                 b_multi;
    logic                 b_free;
    logic                 a_adv;
    logic                 in_fire;
    logic                 in_zero;
    logic                 in_multi;
    logic [KEY_WIDTH-1:0] enc_index;

    assign b_free   = !b_valid || out_ready;
    assign a_adv    = a_valid && b_free;
    assign in_ready = !a_valid || b_free;
    assign in_fire  = in_valid && in_ready;

    // clearing the lowest set bit leaves something only if two or more were set
    assign in_zero  = ~|in_onehot;
    assign in_multi = |(in_onehot & (in_onehot - NR_KEY'(1)));

    always_comb begin
        enc_index = KEY_WIDTH'(DEF_INDEX);
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (a_vec[i]) begin
                enc_index = KEY_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_vec   <= '0;
            a_zero  <= 1'b0;
            a_multi <= 1'b0;
        end else begin
            if (in_fire) begin
                a_valid <= 1'b1;
                a_vec   <= in_onehot;
                a_zero  <= in_zero;
                a_multi <= in_multi;
            end else if (a_adv) begin
                a_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid <= 1'b0;
            b_index <= '0;
            b_err   <= 1'b0;
            b_multi <= 1'b0;
        end else begin
            if (a_adv) begin
                b_valid <= 1'b1;
                b_index <= enc_index;
                b_err   <= a_zero | a_multi;
                b_multi <= a_multi;
            end else if (out_ready) begin
                b_valid <= 1'b0;
            end
        end
    end

    assign out_valid = b_valid;
    assign out_index = b_index;
    assign out_err   = b_err;
    assign out_multi = b_multi;

`ifdef ONEHOT_INDEX_ERRCNT_EN
    logic [15:0] err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (b_valid && out_ready && b_err && err_q != 16'hFFFF) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_onehot_index_encoder.sv
// Scoreboard bench for onehot_index_encoder: directed cases then random valid/ready traffic.
// Expected results come from a bit-counting reference model pushed on each input transfer.
module tb_onehot_index_encoder;

    localparam int NR  = 4;
    localparam int KW  = 2;
    localparam int DEF = 0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NR-1:0] in_onehot = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [KW-1:0] out_index;
    logic          out_err;
    logic          out_multi;
    logic [15:0]   err_cnt;

    onehot_index_encoder #(.NR_KEY(NR), .KEY_WIDTH(KW), .DEF_INDEX(DEF)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_onehot(in_onehot),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_err(out_err), .out_multi(out_multi),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [KW-1:0] idx;
        logic          err;
        logic          multi;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_acc = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b0;

    function automatic exp_t model(logic [NR-1:0] v);
        exp_t e;
        int   ones = $countones(v);
        int   p = 0;
        while (p < NR && !v[p]) p++;
        e.idx   = (p == NR) ? KW'(DEF) : KW'(p);
        e.err   = (ones != 1);
        e.multi = (ones >= 2);
        e.cyc   = 0;
        return e;
    endfunction

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_t e;
            e = model(in_onehot);
            e.cyc = cyc;
            sb.push_back(e);
            n_acc++;
        end
    end

    int            exp_errcnt = 0;
    bit            held_v = 1'b0;
    logic [KW-1:0] held_idx;
    logic          held_err;
    logic          held_multi;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            held_v = 1'b0;
            exp_errcnt = 0;
        end else begin
            check("err_cnt", 32'(err_cnt), 32'(exp_errcnt));
            if (held_v) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_index", 32'(out_index), 32'(held_idx));
                check("hold_err", 32'(out_err), 32'(held_err));
                check("hold_multi", 32'(out_multi), 32'(held_multi));
            end
            held_v = out_valid && !out_ready;
            held_idx = out_index;
            held_err = out_err;
            held_multi = out_multi;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_output", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_index", 32'(out_index), 32'(e.idx));
                    check("out_err", 32'(out_err), 32'(e.err));
                    check("out_multi", 32'(out_multi), 32'(e.multi));
                    if (lat_chk) check("latency", 32'(cyc - e.cyc), 32'd2);
`ifdef ONEHOT_INDEX_ERRCNT_EN
                    if (e.err && exp_errcnt < 65535) exp_errcnt++;
`endif
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        step();
        check("drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic feed(logic [NR-1:0] v);
        in_valid = 1'b1;
        in_onehot = v;
        step();
    endtask

    logic [NR-1:0] bp_vec [3];

    initial begin
        int n0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_out_index", 32'(out_index), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_out_multi", 32'(out_multi), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        out_ready = 1'b1;
        lat_chk = 1'b1;
        for (int k = 0; k < NR; k++) feed(NR'(1) << k);
        feed(4'b0000);
        feed(4'b0110);
        in_valid = 1'b0;
        repeat (4) step();
        lat_chk = 1'b0;
        drain();

        bp_vec[0] = 4'b0100;
        bp_vec[1] = 4'b1100;
        bp_vec[2] = 4'b0000;
        out_ready = 1'b0;
        n0 = n_acc;
        in_valid = 1'b1;
        in_onehot = bp_vec[0];
        for (int i = 0; i < 5; i++) begin
            step();
            if (n_acc - n0 < 3) in_onehot = bp_vec[n_acc - n0];
        end
        check("bp_accepted", 32'(n_acc - n0), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 10 && n_acc - n0 < 3; i++) begin
            step();
            if (n_acc - n0 < 3) in_onehot = bp_vec[n_acc - n0];
        end
        check("bp_all_accepted", 32'(n_acc - n0), 32'd3);
        drain();

        out_ready = 1'b0;
        feed(4'b1111);
        feed(4'b0000);
        feed(4'b0001);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_in_ready", 32'(in_ready), 32'd1);
        check("async_err_cnt", 32'(err_cnt), 32'd0);
        in_valid = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        step();

        n0 = n_acc;
        for (int g = 0; g < 60000 && n_acc - n0 < 10000; g++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: in_onehot = '0;
                1: in_onehot = NR'($urandom);
                default: in_onehot = NR'(1) << $urandom_range(0, NR - 1);
            endcase
            step();
        end
        check("random_count", 32'(n_acc - n0), 32'd10000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
